// File: rtl/spi_slave.sv
// Mode-0 SPI slave: pins oversampled in the clock domain, received words go out on
// the out/put stream, transmit words are pulled from the in/get/empty source.
//
// state | meaning
// IDLE  | chip select high; spi_miso parked high
// LOAD  | one cycle after cs_n fall; fetch first transmit word
// SHIFT | shifting on synced sclk edges until cs_n rises
module spi_slave #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         spi_cs_n,
   input  logic         spi_clock,
   input  logic         spi_mosi,
   output logic         spi_miso,
   input  logic [W-1:0] in,
   output logic         get,
   input  logic         empty,
   output logic [W-1:0] out,
   output logic         put
);

   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

   state_t        state;
   logic [2:0]    cs_q;
   logic [2:0]    sclk_q;
   logic [1:0]    mosi_q;
   logic [CW-1:0] count;
   logic [W-1:0]  rx;
   logic [W-1:0]  tx;
   logic          reload;

   logic          cs_fall;
   logic          cs_rise;
   logic          sclk_rise;
   logic          sclk_fall;
   logic [W-1:0]  rx_next;

   // Events compare sync stage 2 against stage 3; mosi only needs two stages.
   assign cs_fall   =  cs_q[2]   & ~cs_q[1];
   assign cs_rise   = ~cs_q[2]   &  cs_q[1];
   assign sclk_rise = ~sclk_q[2] &  sclk_q[1];
   assign sclk_fall =  sclk_q[2] & ~sclk_q[1];
   assign rx_next   = {rx[W-2:0], mosi_q[1]};

   // get marks the cycle in which `in` is captured into tx, so it must be
   // combinational alongside the capture; cs_n rise pre-empts any fetch.
   assign get = ~cs_rise & ~empty &
                ((state == LOAD) | ((state == SHIFT) & sclk_fall & reload));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cs_q     <= 3'b111;
         sclk_q   <= 3'b000;
         mosi_q   <= 2'b00;
         state    <= IDLE;
         count    <= '0;
         rx       <= '0;
         tx       <= '1;
         reload   <= 1'b0;
         out      <= '0;
         put      <= 1'b0;
         spi_miso <= 1'b1;
      end else begin
         cs_q   <= {cs_q[1:0], spi_cs_n};
         sclk_q <= {sclk_q[1:0], spi_clock};
         mosi_q <= {mosi_q[0], spi_mosi};
         put    <= 1'b0;

         if (cs_rise) begin
            state    <= IDLE;
            spi_miso <= 1'b1;
            count    <= '0;
            reload   <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  spi_miso <= 1'b1;
                  if (cs_fall) state <= LOAD;
               end
               LOAD: begin
                  tx       <= empty ? '1 : in;
                  spi_miso <= empty ? 1'b1 : in[W-1];
                  count    <= '0;
                  reload   <= 1'b0;
                  state    <= SHIFT;
               end
               SHIFT: begin
                  if (sclk_rise) begin
                     rx <= rx_next;
                     if (count == LAST) begin
                        out    <= rx_next;
                        put    <= 1'b1;
                        count  <= '0;
                        reload <= 1'b1;
                     end else begin
                        count <= count + CW'(1);
                     end
                  end else if (sclk_fall) begin
                     if (reload) begin
                        tx       <= empty ? '1 : in;
                        spi_miso <= empty ? 1'b1 : in[W-1];
                        reload   <= 1'b0;
                     end else begin
                        tx       <= {tx[W-2:0], 1'b1};
                        spi_miso <= tx[W-2];
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave (W=8): a bit-bang mode-0 master task, a small
// word source, and a put monitor, all checked against hand-computed values.
module tb_spi_slave;

   logic       clock;
   logic       reset_n;
   logic       spi_cs_n;
   logic       spi_clock;
   logic       spi_mosi;
   logic       spi_miso;
   logic [7:0] in;
   logic       get;
   logic       empty;
   logic [7:0] out;
   logic       put;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] src_words [0:3];
   int         src_len  = 0;
   int         src_base = 0;
   int         src_cnt  = 0;
   int         src_idx;

   int         put_cnt  = 0;
   int         put_wide = 0;
   int         get_wide = 0;
   logic       put_q    = 1'b0;
   logic       get_q    = 1'b0;
   logic [7:0] out_hist [0:7];

   spi_slave #(.W(8)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .spi_cs_n (spi_cs_n),
      .spi_clock(spi_clock),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso),
      .in       (in),
      .get      (get),
      .empty    (empty),
      .out      (out),
      .put      (put)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   assign src_idx = src_cnt - src_base;
   assign empty   = (src_idx >= src_len);
   assign in      = (src_idx >= 0 && src_idx < 4) ? src_words[src_idx] : 8'h00;

   // Source advances on the edge that captures the word.
   always @(posedge clock) begin
      if (get) src_cnt <= src_cnt + 1;
   end

   always @(negedge clock) begin
      if (put) begin
         out_hist[put_cnt % 8] <= out;
         put_cnt <= put_cnt + 1;
      end
      if (put && put_q) put_wide <= put_wide + 1;
      if (get && get_q) get_wide <= get_wide + 1;
      put_q <= put;
      get_q <= get;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic src_set(input logic [7:0] w0, input logic [7:0] w1, input int len);
      src_words[0] = w0;
      src_words[1] = w1;
      src_words[2] = 8'h00;
      src_words[3] = 8'h00;
      src_base     = src_cnt;
      src_len      = len;
   endtask

   // Mode-0 master: mosi changes with sclk low, miso sampled at the rise.
   // Frame ends with sclk still high so the trailing fall lands in IDLE.
   task automatic xfer(input int nbits, input logic [15:0] tx, input bit end_frame,
                       input bit lat, output logic [15:0] rx);
      rx = '0;
      spi_cs_n = 1'b0;
      repeat (8) @(negedge clock);
      for (int i = nbits - 1; i >= 0; i--) begin
         spi_mosi = tx[i];
         repeat (4) @(negedge clock);
         rx[i] = spi_miso;
         spi_clock = 1'b1;
         if (lat && i == 0) begin
            @(negedge clock); chk("lat_k0", put, 1'b0);
            @(negedge clock); chk("lat_k1", put, 1'b0);
            @(negedge clock); chk("lat_k2", put, 1'b1);
            @(negedge clock); chk("lat_k3", put, 1'b0);
         end else begin
            repeat (4) @(negedge clock);
         end
         if (i != 0) spi_clock = 1'b0;
      end
      if (end_frame) begin
         spi_cs_n = 1'b1;
         repeat (4) @(negedge clock);
         spi_clock = 1'b0;
         repeat (4) @(negedge clock);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] rx;
      int p0;
      int g0;

      reset_n   = 1'b0;
      spi_cs_n  = 1'b1;
      spi_clock = 1'b0;
      spi_mosi  = 1'b0;
      src_set(8'h00, 8'h00, 0);
      repeat (3) @(negedge clock);
      chk("rst_out",  out,      8'h00);
      chk("rst_put",  put,      1'b0);
      chk("rst_get",  get,      1'b0);
      chk("rst_miso", spi_miso, 1'b1);
      reset_n = 1'b1;
      repeat (4) @(negedge clock);

      // Loopback: master sends A5, source holds 3C.
      src_set(8'h3C, 8'h00, 1);
      p0 = put_cnt; g0 = src_cnt;
      xfer(8, 16'h00A5, 1'b1, 1'b0, rx);
      chk("t1_puts", put_cnt - p0,  1);
      chk("t1_out",  out_hist[p0 % 8], 8'hA5);
      chk("t1_gets", src_cnt - g0,  1);
      chk("t1_rx",   rx[7:0],       8'h3C);

      // Empty source: master sees all-ones, no get.
      src_set(8'h00, 8'h00, 0);
      p0 = put_cnt; g0 = src_cnt;
      xfer(8, 16'h0000, 1'b1, 1'b0, rx);
      chk("t2_puts", put_cnt - p0,  1);
      chk("t2_out",  out_hist[p0 % 8], 8'h00);
      chk("t2_gets", src_cnt - g0,  0);
      chk("t2_rx",   rx[7:0],       8'hFF);

      // Two back-to-back words under one chip select.
      src_set(8'h11, 8'h22, 2);
      p0 = put_cnt; g0 = src_cnt;
      xfer(16, 16'h4865, 1'b1, 1'b0, rx);
      chk("t3_puts", put_cnt - p0,        2);
      chk("t3_out0", out_hist[p0 % 8],       8'h48);
      chk("t3_out1", out_hist[(p0 + 1) % 8], 8'h65);
      chk("t3_gets", src_cnt - g0,        2);
      chk("t3_rx",   rx,                  16'h1122);

      // Abort after 5 bits of F0, then a clean 0F.
      src_set(8'h77, 8'h00, 1);
      p0 = put_cnt;
      xfer(5, 16'h001E, 1'b1, 1'b0, rx);
      chk("t4_abort_puts", put_cnt - p0, 0);
      chk("t4_miso_idle",  spi_miso,     1'b1);
      src_set(8'h99, 8'h00, 1);
      p0 = put_cnt;
      xfer(8, 16'h000F, 1'b1, 1'b0, rx);
      chk("t4_puts", put_cnt - p0,     1);
      chk("t4_out",  out_hist[p0 % 8], 8'h0F);
      chk("t4_rx",   rx[7:0],          8'h99);
      chk("t4_out_pin", out,           8'h0F);

      // Async reset three bits into a word.
      src_set(8'hC3, 8'h00, 1);
      xfer(3, 16'h0002, 1'b0, 1'b0, rx);
      reset_n = 1'b0;
      #1;
      chk("t5_rst_put",  put,      1'b0);
      chk("t5_rst_get",  get,      1'b0);
      chk("t5_rst_out",  out,      8'h00);
      chk("t5_rst_miso", spi_miso, 1'b1);
      spi_cs_n  = 1'b1;
      spi_clock = 1'b0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (4) @(negedge clock);

      // Full 5A transfer afterwards, with put latency check on the 8th rise.
      src_set(8'hE7, 8'h00, 1);
      p0 = put_cnt;
      xfer(8, 16'h005A, 1'b1, 1'b1, rx);
      chk("t5_puts", put_cnt - p0,     1);
      chk("t5_out",  out_hist[p0 % 8], 8'h5A);
      chk("t5_rx",   rx[7:0],          8'hE7);

      chk("put_width", put_wide, 0);
      chk("get_width", get_wide, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
